// File: rtl/rt_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rt_access_sequencer
//  Description : Single-word access sequencer for a racetrack array. Shifts
//                the selected track class to the requested domain position
//                one step per cycle, then fires word line plus read current
//                or write enable, and returns a one-cycle response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module rt_access_sequencer #(
  parameter int Nb     = 32,
  parameter int Np     = 8,
  parameter int Nr     = 4,
  parameter int NMU    = 8,
  parameter int RD_LAT = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rstn_i,
  input  logic                                    req_i,
  output logic                                    gnt_o,
  input  logic [$clog2(Np)+$clog2(Nb)-1:0]        addr_i,
  input  logic                                    we_i,
  input  logic [1:0]                              tgt_i,
  input  logic [Nr*NMU-1:0]                       wdata_i,
  output logic                                    rvalid_o,
  output logic [Nr*NMU-1:0]                       rdata_o,
  output logic                                    err_o,
  output logic                                    bz_s_o,
  output logic                                    bz_m_o,
  output logic                                    cur_s_d_o,
  output logic                                    cur_s_m_o,
  output logic                                    cur_s_p_o,
  output logic                                    cur_m_d_o,
  output logic                                    cur_m_m_o,
  output logic                                    cur_m_p_o,
  output logic                                    rd_cur_d_o,
  output logic                                    rd_cur_m_o,
  output logic                                    rd_cur_p_o,
  output logic                                    we_d_o,
  output logic                                    we_m_o,
  output logic                                    we_p_o,
  output logic [Nr*NMU-1:0]                       wdata_o,
  output logic [Nb-1:0]                           word_lines_o,
  input  logic [Nr*NMU-1:0]                       r_data_d_i,
  input  logic [Nr*NMU-1:0]                       r_data_m_i,
  input  logic [Nr*NMU-1:0]                       r_data_p_i
);

  localparam int c_W  = Nr * NMU;
  localparam int c_WL = $clog2(Nb);
  localparam int c_PW = $clog2(Np);
  localparam int c_AW = c_PW + c_WL;
  localparam int c_LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_READ   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Latched request fields
  logic [c_AW-1:0]   r_addr;
  logic              r_we;
  logic [1:0]        r_tgt;
  logic [c_W-1:0]    r_wdata;

  // Current domain position of each track class
  logic [c_PW-1:0]   r_pos_d, r_pos_m, r_pos_p;
  logic [c_PW-1:0]   w_pos_d_nxt, w_pos_m_nxt, w_pos_p_nxt;

  // Read-hold cycle counter (ACCESS + READ cycles)
  logic [c_LW-1:0]   r_lat, w_lat_nxt;

  // Registered control outputs; class vectors are {p, m, d}
  logic              r_bz_s, r_bz_m, r_rvalid, r_err;
  logic [2:0]        r_cur_s, r_cur_m, r_rd_cur, r_we_cls;
  logic [Nb-1:0]     r_wl;
  logic [c_W-1:0]    r_rdata;

  logic              w_bz_s, w_bz_m, w_rvalid, w_err;
  logic [2:0]        w_cur_s, w_cur_m, w_rd_cur, w_we_cls;
  logic [Nb-1:0]     w_wl;
  logic [c_W-1:0]    w_rdata;

  // Effective request fields: live inputs in the grant cycle, latched otherwise
  logic              w_take;
  logic [c_AW-1:0]   w_addr;
  logic              w_we;
  logic [1:0]        w_tgt;
  logic [c_PW-1:0]   w_tpos;
  logic [c_WL-1:0]   w_wlidx;
  logic [c_PW-1:0]   w_cur_pos, w_step_pos, w_npos;
  logic [2:0]        w_cls;
  logic [Nb-1:0]     w_wl_onehot;
  logic [c_W-1:0]    w_rsel;

  function automatic logic [c_PW-1:0] f_pos_sel(
    input logic [1:0]      t,
    input logic [c_PW-1:0] pd,
    input logic [c_PW-1:0] pm,
    input logic [c_PW-1:0] pp
  );
    logic [c_PW-1:0] v;
    case (t)
      2'd0:    v = pd;
      2'd1:    v = pm;
      default: v = pp;
    endcase
    return v;
  endfunction

  assign gnt_o = req_i & (r_state == ST_IDLE) & rstn_i;

  // Request field selection, class decode and read-data mux
  always_comb begin
    w_take      = req_i & (r_state == ST_IDLE);
    w_addr      = w_take ? addr_i : r_addr;
    w_we        = w_take ? we_i   : r_we;
    w_tgt       = w_take ? tgt_i  : r_tgt;
    w_tpos      = w_addr[c_AW-1:c_WL];
    w_wlidx     = w_addr[c_WL-1:0];
    w_wl_onehot = {{(Nb-1){1'b0}}, 1'b1} << w_wlidx;
    case (w_tgt)
      2'd0:    begin w_cls = 3'b001; w_rsel = r_data_d_i; end
      2'd1:    begin w_cls = 3'b010; w_rsel = r_data_m_i; end
      2'd2:    begin w_cls = 3'b100; w_rsel = r_data_p_i; end
      default: begin w_cls = 3'b000; w_rsel = '0;         end
    endcase
  end

  // Next-state, position stepping and read-hold counting
  always_comb begin
    w_state_nxt = r_state;
    w_pos_d_nxt = r_pos_d;
    w_pos_m_nxt = r_pos_m;
    w_pos_p_nxt = r_pos_p;
    w_lat_nxt   = r_lat;
    w_cur_pos   = f_pos_sel(w_tgt, r_pos_d, r_pos_m, r_pos_p);
    w_step_pos  = (w_tpos > w_cur_pos) ? (w_cur_pos + 1'b1) : (w_cur_pos - 1'b1);
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          if (tgt_i == 2'd3)            w_state_nxt = ST_RESP;
          else if (w_cur_pos == w_tpos) w_state_nxt = ST_ACCESS;
          else                          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        case (w_tgt)
          2'd0:    w_pos_d_nxt = w_step_pos;
          2'd1:    w_pos_m_nxt = w_step_pos;
          default: w_pos_p_nxt = w_step_pos;
        endcase
        if (w_step_pos == w_tpos) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_we || (RD_LAT <= 1)) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_READ;
          w_lat_nxt   = c_LW'(1);
        end
      end
      ST_READ: begin
        if (r_lat == c_LW'(RD_LAT - 1)) w_state_nxt = ST_RESP;
        else                            w_lat_nxt   = r_lat + 1'b1;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control values for the coming cycle, decoded from next state/positions
  always_comb begin
    w_bz_s   = 1'b0;
    w_bz_m   = 1'b0;
    w_cur_s  = 3'b000;
    w_cur_m  = 3'b000;
    w_rd_cur = 3'b000;
    w_we_cls = 3'b000;
    w_wl     = '0;
    w_rvalid = 1'b0;
    w_err    = 1'b0;
    w_rdata  = '0;
    w_npos   = f_pos_sel(w_tgt, w_pos_d_nxt, w_pos_m_nxt, w_pos_p_nxt);
    case (w_state_nxt)
      ST_SHIFT: begin
        if (w_tpos > w_npos) begin
          w_cur_s = w_cls;
          w_bz_s  = 1'b1;
        end else begin
          w_cur_m = w_cls;
          w_bz_m  = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_wl = w_wl_onehot;
        if (w_we) w_we_cls = w_cls;
        else      w_rd_cur = w_cls;
      end
      ST_READ: begin
        w_wl     = w_wl_onehot;
        w_rd_cur = w_cls;
      end
      ST_RESP: begin
        w_rvalid = 1'b1;
        w_err    = (w_tgt == 2'd3);
        // Capture happens on the edge that ends the last read-hold cycle
        if (!w_we && (w_tgt != 2'd3)) w_rdata = w_rsel;
      end
      default: ;
    endcase
  end

  // State, positions and latched request fields
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_pos_d <= '0;
      r_pos_m <= '0;
      r_pos_p <= '0;
      r_lat   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_tgt   <= 2'd0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos_d <= w_pos_d_nxt;
      r_pos_m <= w_pos_m_nxt;
      r_pos_p <= w_pos_p_nxt;
      r_lat   <= w_lat_nxt;
      if (w_take) begin
        r_addr  <= addr_i;
        r_we    <= we_i;
        r_tgt   <= tgt_i;
        r_wdata <= wdata_i;
      end
    end
  end

  // Registered array controls and response, cleared asynchronously on reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bz_s   <= 1'b0;
      r_bz_m   <= 1'b0;
      r_cur_s  <= 3'b000;
      r_cur_m  <= 3'b000;
      r_rd_cur <= 3'b000;
      r_we_cls <= 3'b000;
      r_wl     <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_bz_s   <= w_bz_s;
      r_bz_m   <= w_bz_m;
      r_cur_s  <= w_cur_s;
      r_cur_m  <= w_cur_m;
      r_rd_cur <= w_rd_cur;
      r_we_cls <= w_we_cls;
      r_wl     <= w_wl;
      r_rvalid <= w_rvalid;
      r_err    <= w_err;
      r_rdata  <= w_rdata;
    end
  end

  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign bz_s_o       = r_bz_s;
  assign bz_m_o       = r_bz_m;
  assign cur_s_d_o    = r_cur_s[0];
  assign cur_s_m_o    = r_cur_s[1];
  assign cur_s_p_o    = r_cur_s[2];
  assign cur_m_d_o    = r_cur_m[0];
  assign cur_m_m_o    = r_cur_m[1];
  assign cur_m_p_o    = r_cur_m[2];
  assign rd_cur_d_o   = r_rd_cur[0];
  assign rd_cur_m_o   = r_rd_cur[1];
  assign rd_cur_p_o   = r_rd_cur[2];
  assign we_d_o       = r_we_cls[0];
  assign we_m_o       = r_we_cls[1];
  assign we_p_o       = r_we_cls[2];
  assign wdata_o      = r_wdata;
  assign word_lines_o = r_wl;

endmodule
`default_nettype wire
